// File: rtl/psm_arbiter.sv
// psm_arbiter: shares one point_scalar_mult engine between two requesters.
// Round-robin grant, one job in flight, result returned on the owner's channel.
// Optional watchdog: define PSM_ARB_TIMEOUT_EN to compile in the RUN-cycle
// counter and the ABORT state (TIMEOUT_CYCLES is ignored otherwise).

`ifndef WIDTH
`define WIDTH 255
`endif
`ifndef SCALAR_WIDTH
`define SCALAR_WIDTH 255
`endif

module psm_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000,
  parameter int          DATA_W         = `WIDTH + 1,
  parameter int          COEF_W         = `SCALAR_WIDTH + 1
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_req_x,
  input  logic [DATA_W-1:0] r0_req_y,
  input  logic              r0_req_zero,
  input  logic [COEF_W-1:0] r0_req_c,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  // requester 1
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_req_x,
  input  logic [DATA_W-1:0] r1_req_y,
  input  logic              r1_req_zero,
  input  logic [COEF_W-1:0] r1_req_c,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  // shared response data
  output logic [DATA_W-1:0] rsp_x,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_zero,
  output logic              rsp_err,
  // engine side
  output logic              eng_reset,
  output logic [DATA_W-1:0] eng_x1,
  output logic [DATA_W-1:0] eng_y1,
  output logic              eng_zero1,
  output logic [COEF_W-1:0] eng_c,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_x3,
  input  logic [DATA_W-1:0] eng_y3,
  input  logic              eng_zero3
);

`ifdef PSM_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP, ST_ABORT} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_t;
`endif

  state_t state, state_nxt;
  logic   last;      // requester that won the previous grant
  logic   owner;     // requester owning the job in flight
  logic   grant;
  logic   acc_hs;
  logic   rsp_hs;

  // Round-robin pick: a lone requester wins, otherwise the one that did not win last
  always_comb begin
    grant = ~last;
    if (r0_req_valid && !r1_req_valid) begin
      grant = 1'b0;
    end else if (r1_req_valid && !r0_req_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by reset so nothing looks acceptable while reset is held
  assign r0_req_ready = reset & (state == ST_IDLE) & ~grant;
  assign r1_req_ready = reset & (state == ST_IDLE) &  grant;
  assign acc_hs       = (r0_req_valid & r0_req_ready) | (r1_req_valid & r1_req_ready);

  assign r0_rsp_valid = (state == ST_RESP) & ~owner;
  assign r1_rsp_valid = (state == ST_RESP) &  owner;
  assign rsp_hs       = (r0_rsp_valid & r0_rsp_ready) | (r1_rsp_valid & r1_rsp_ready);

  // Engine is held in reset everywhere but RUN; the LOAD pulse clears stale done
  assign eng_reset = (state != ST_RUN);

`ifdef PSM_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        wd_expired;

  assign wd_expired = (wd_cnt == TIMEOUT_CYCLES - 32'd1);

  // Watchdog: counts RUN cycles, restarted on every LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ST_LOAD) begin
      wd_cnt <= '0;
    end else if (state == ST_RUN) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Next-state logic; done takes priority over a same-cycle watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc_hs) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (eng_done) state_nxt = ST_RESP;
`ifdef PSM_ARB_TIMEOUT_EN
        else if (wd_expired) state_nxt = ST_ABORT;
`endif
      end
      ST_RESP: begin
        if (rsp_hs) state_nxt = ST_IDLE;
      end
`ifdef PSM_ARB_TIMEOUT_EN
      ST_ABORT: begin
        state_nxt = ST_RESP;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus grant bookkeeping; requester 0 has first priority out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc_hs) begin
        owner <= grant;
        last  <= grant;
      end
    end
  end

  // Latch the winner's operands; they stay put for the whole job
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_x1    <= '0;
      eng_y1    <= '0;
      eng_zero1 <= 1'b1;
      eng_c     <= '0;
    end else if (acc_hs) begin
      if (grant) begin
        eng_x1    <= r1_req_x;
        eng_y1    <= r1_req_y;
        eng_zero1 <= r1_req_zero;
        eng_c     <= r1_req_c;
      end else begin
        eng_x1    <= r0_req_x;
        eng_y1    <= r0_req_y;
        eng_zero1 <= r0_req_zero;
        eng_c     <= r0_req_c;
      end
    end
  end

  // Capture the engine result (or the abort result) for the response phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_x    <= '0;
      rsp_y    <= '0;
      rsp_zero <= 1'b1;
    end else if (state == ST_RUN && eng_done) begin
      rsp_x    <= eng_x3;
      rsp_y    <= eng_y3;
      rsp_zero <= eng_zero3;
    end
`ifdef PSM_ARB_TIMEOUT_EN
    else if (state == ST_ABORT) begin
      rsp_x    <= '0;
      rsp_y    <= '0;
      rsp_zero <= 1'b1;
    end
`endif
  end

`ifdef PSM_ARB_TIMEOUT_EN
  // Error flag: cleared by a normal completion, set by a watchdog abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_err <= 1'b0;
    end else if (state == ST_RUN && eng_done) begin
      rsp_err <= 1'b0;
    end else if (state == ST_ABORT) begin
      rsp_err <= 1'b1;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
